// File: rtl/latch_wr_sched_if.sv
// latch_wr_sched_if: requester, clear and latch-pin signals of the latch write scheduler
interface latch_wr_sched_if #(parameter int DATA_W = 8);
    logic              req_a;
    logic [DATA_W-1:0] data_a;
    logic              ack_a;
    logic              req_b;
    logic [DATA_W-1:0] data_b;
    logic              ack_b;
    logic              clr_req;
    logic              clr_ack;
    logic [DATA_W-1:0] lat_data;
    logic              lat_en;
    logic              lat_rst;
    logic              busy;
    logic              last_src;
    modport master (
        output req_a, data_a, req_b, data_b, clr_req,
        input  ack_a, ack_b, clr_ack, lat_data, lat_en, lat_rst, busy, last_src
    );
    modport slave (
        input  req_a, data_a, req_b, data_b, clr_req,
        output ack_a, ack_b, clr_ack, lat_data, lat_en, lat_rst, busy, last_src
    );
endinterface

// File: rtl/latch_wr_sched.sv
// latch_wr_sched: arbitrates two writers and a clear onto a holding latch,
// sequencing data setup, enable pulse and hold with registered outputs.
module latch_wr_sched #(
    parameter int DATA_W       = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int EN_CYCLES    = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input logic clk,
    input logic reset,
    latch_wr_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, ACK, CLEAR, CLR_ACK} state_t;
    localparam logic [3:0] L_S = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] L_E = 4'(EN_CYCLES - 1);
    localparam logic [3:0] L_H = 4'(HOLD_CYCLES - 1);
    state_t            r_state, w_next;
    logic [3:0]        r_cnt, w_cnt;
    logic              r_src, r_pref_b, w_grant_b;
    logic [DATA_W-1:0] r_lat_data;
    logic              r_lat_en, r_lat_rst, r_ack_a, r_ack_b, r_clr_ack, r_busy, r_last_src;
    // B wins only when it alone requests or it is B's turn
    assign w_grant_b = bus.req_b & (~bus.req_a | r_pref_b);
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (bus.clr_req) begin
                    w_next = CLEAR;
                    w_cnt  = L_E;
                end else if (bus.req_a | bus.req_b) begin
                    w_next = SETUP;
                    w_cnt  = L_S;
                end
            end
            SETUP: begin
                w_next = (r_cnt == 4'd0) ? ENABLE : SETUP;
                w_cnt  = (r_cnt == 4'd0) ? L_E : r_cnt - 4'd1;
            end
            ENABLE: begin
                w_next = (r_cnt == 4'd0) ? HOLD : ENABLE;
                w_cnt  = (r_cnt == 4'd0) ? L_H : r_cnt - 4'd1;
            end
            HOLD: begin
                w_next = (r_cnt == 4'd0) ? ACK : HOLD;
                w_cnt  = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            end
            CLEAR: begin
                w_next = (r_cnt == 4'd0) ? CLR_ACK : CLEAR;
                w_cnt  = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            end
            ACK:     w_next = IDLE;
            CLR_ACK: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_src      <= 1'b0;
            r_pref_b   <= 1'b0;
            r_lat_data <= '0;
            r_lat_en   <= 1'b0;
            r_lat_rst  <= 1'b0;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_clr_ack  <= 1'b0;
            r_busy     <= 1'b0;
            r_last_src <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt;
            r_lat_en  <= w_next == ENABLE;
            r_lat_rst <= w_next == CLEAR;
            r_ack_a   <= w_next == ACK && !r_src;
            r_ack_b   <= w_next == ACK && r_src;
            r_clr_ack <= w_next == CLR_ACK;
            r_busy    <= w_next != IDLE;
            if (r_state == IDLE && w_next == SETUP) begin
                r_src      <= w_grant_b;
                r_lat_data <= w_grant_b ? bus.data_b : bus.data_a;
            end
            if (w_next == ACK) begin
                r_last_src <= r_src;
                r_pref_b   <= ~r_src;
            end
        end
    end
    assign bus.lat_data = r_lat_data;
    assign bus.lat_en   = r_lat_en;
    assign bus.lat_rst  = r_lat_rst;
    assign bus.ack_a    = r_ack_a;
    assign bus.ack_b    = r_ack_b;
    assign bus.clr_ack  = r_clr_ack;
    assign bus.busy     = r_busy;
    assign bus.last_src = r_last_src;
endmodule
